// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output protocol: bus widths,
// pooling FSM states and the default frame geometry (28x28 input image).
package conv_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  // Default geometry: 28x28 image -> 26x26 conv map -> 13x13 pooled map.
  localparam int CH = 26;
  localparam int CW = 26;
  localparam int PH = CH / 2;
  localparam int PW = CW / 2;

  typedef enum logic [2:0] {
    COLLECT,
    RD,
    FOLD,
    EMIT,
    HOLD
  } state_t;

endpackage

// File: rtl/fmap_ram.sv
// Single-port feature-map RAM with synchronous write and one-cycle registered read.
module fmap_ram
  import conv_pkg::*;
#(
  parameter int DEPTH = CH * CW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pool_reader.sv
// Captures a conv-map write stream into local RAM, then replays it as 2x2
// stride-2 max pooling on the same data/address/store/done protocol.
module pool_reader
  import conv_pkg::*;
#(
  parameter int H = 28,
  parameter int W = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_store,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_done,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_store,
  output logic              out_done,
  output logic              busy,
  output logic              err
);

  localparam int CH_L  = (H == CH + 2) ? CH : H - 2;
  localparam int CW_L  = (W == CW + 2) ? CW : W - 2;
  localparam int PH_L  = (H == CH + 2) ? PH : CH_L / 2;
  localparam int PW_L  = (W == CW + 2) ? PW : CW_L / 2;
  localparam int DEPTH = CH_L * CW_L;

  localparam logic [ADDR_W-1:0] CW_A    = ADDR_W'(CW_L);
  localparam logic [ADDR_W-1:0] PW_A    = ADDR_W'(PW_L);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PR_LAST = ADDR_W'(PH_L - 1);
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PW_L - 1);

  state_t            state_q;
  logic [1:0]        s_q;
  logic [ADDR_W-1:0] pr_q, pc_q;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_store_q, out_done_q, busy_q, err_q;

  logic [ADDR_W-1:0] row_d, col_d, rd_addr_d, ram_addr_d;
  logic [DATA_W-1:0] ram_rdata, fold_d;
  logic              in_range_d, ram_we_d, last_win_d;

  // Sub-index s selects the window corner: bit 1 picks the row, bit 0 the column.
  always_comb begin
    row_d      = {pr_q[ADDR_W-2:0], s_q[1]};
    col_d      = {pc_q[ADDR_W-2:0], s_q[0]};
    rd_addr_d  = row_d * CW_A + col_d;
    in_range_d = in_addr < DEPTH_A;
    ram_we_d   = (state_q == COLLECT) && in_store && in_range_d;
    ram_addr_d = (state_q == COLLECT) ? in_addr : rd_addr_d;
    fold_d     = (max_q > ram_rdata) ? max_q : ram_rdata;
    last_win_d = (pr_q == PR_LAST) && (pc_q == PC_LAST);
  end

  fmap_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_d),
    .addr (ram_addr_d),
    .wdata(in_data),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      s_q         <= '0;
      pr_q        <= '0;
      pc_q        <= '0;
      max_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_store_q <= 1'b0;
      out_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (in_store && ((state_q != COLLECT) || !in_range_d)) begin
        err_q <= 1'b1;
      end
      out_store_q <= 1'b0;

      case (state_q)
        COLLECT: begin
          if (in_done) begin
            state_q <= RD;
            s_q     <= '0;
            pr_q    <= '0;
            pc_q    <= '0;
            busy_q  <= 1'b1;
          end
        end

        RD: begin
          // Data for corner s-1 arrives now; the first corner loads rather than compares.
          if (s_q == 2'd1) begin
            max_q <= ram_rdata;
          end else if (s_q != 2'd0) begin
            max_q <= fold_d;
          end
          s_q <= s_q + 2'd1;
          if (s_q == 2'd3) begin
            state_q <= FOLD;
          end
        end

        FOLD: begin
          out_store_q <= 1'b1;
          out_data_q  <= fold_d;
          out_addr_q  <= pr_q * PW_A + pc_q;
          state_q     <= EMIT;
        end

        EMIT: begin
          if (last_win_d) begin
            state_q    <= HOLD;
            out_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q <= RD;
            if (pc_q == PC_LAST) begin
              pc_q <= '0;
              pr_q <= pr_q + 1'b1;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end

        HOLD: begin
          if (!in_done) begin
            out_done_q <= 1'b0;
            state_q    <= COLLECT;
          end
        end

        default: state_q <= COLLECT;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_store = out_store_q;
  assign out_done  = out_done_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pool_reader.sv
// Directed bench for pool_reader: ramp, single-hot, dropped-write, reset and
// back-to-back frames, checked against a table and a reference pooling model.
module tb_pool_reader;
  import conv_pkg::*;

  localparam int NPIX = 676;
  localparam int NW   = 169;
  localparam int CWM  = 26;
  localparam int PWM  = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_store;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_done;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_store;
  logic              out_done;
  logic              busy;
  logic              err;

  pool_reader #(.H(28), .W(28)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_store (in_store),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_done  (in_done),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_store(out_store),
    .out_done (out_done),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 ramp, 1 single hot, 2 inverted ramp
    int addr;
    int exp;
  } vec_t;

  vec_t vecs[14];

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  img [NPIX];
  int          cap_by_addr [NW];
  int          cap_addr [NW];
  int          cap_cyc [NW];
  int          cap_cnt = 0;

  always @(negedge clk) begin
    if (out_store) begin
      if (cap_cnt < NW) begin
        cap_addr[cap_cnt] = int'(out_addr);
        cap_cyc[cap_cnt]  = cyc;
      end
      if (int'(out_addr) < NW) cap_by_addr[int'(out_addr)] = int'(out_data);
      cap_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill(input int kind);
    for (int a = 0; a < NPIX; a++) begin
      case (kind)
        0:       img[a] = 8'(a % 256);
        1:       img[a] = (a == 53) ? 8'd200 : 8'd0;
        default: img[a] = 8'(255 - (a % 256));
      endcase
    end
  endtask

  task automatic write_frame(input bit bad_write);
    for (int a = 0; a < NPIX; a++) begin
      @(negedge clk);
      in_store = 1'b1;
      in_addr  = 10'(a);
      in_data  = img[a];
    end
    if (bad_write) begin
      @(negedge clk);
      in_addr = 10'd700;
      in_data = 8'd9;
    end
    @(negedge clk);
    in_store = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    check("busy_collect", int'(busy), 0);
  endtask

  task automatic pool_frame(input int kind, input bit inject);
    int start, done_off, off, badgap, badord, mism, m, base, pr, pc;
    for (int k = 0; k < NW; k++) cap_by_addr[k] = -1;
    cap_cnt = 0;
    @(negedge clk);
    in_done = 1'b1;
    start   = cyc;
    check("busy_cycle0", int'(busy), 0);
    done_off = -1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      off = cyc - start;
      if (inject && off == 2) begin
        in_store = 1'b1;
        in_addr  = '0;
        in_data  = 8'd255;
      end else if (inject && off == 3) begin
        in_store = 1'b0;
      end
      if (off == 3) check("busy_rd", int'(busy), 1);
      if (out_done) begin
        done_off = off;
        break;
      end
    end
    check("done_cycle", done_off, 1015);
    check("busy_hold", int'(busy), 0);
    check("strobe_count", cap_cnt, NW);
    check("first_strobe", (cap_cnt > 0) ? cap_cyc[0] - start : -1, 6);
    badgap = 0;
    badord = 0;
    for (int j = 0; j < NW && j < cap_cnt; j++) begin
      if (j > 0 && cap_cyc[j] - cap_cyc[j-1] != 6) badgap++;
      if (cap_addr[j] != j) badord++;
    end
    check("strobe_gap", badgap, 0);
    check("strobe_order", badord, 0);

    mism = 0;
    for (int k = 0; k < NW; k++) begin
      pr   = k / PWM;
      pc   = k % PWM;
      base = 2 * pr * CWM + 2 * pc;
      m    = int'(img[base]);
      if (int'(img[base+1]) > m) m = int'(img[base+1]);
      if (int'(img[base+CWM]) > m) m = int'(img[base+CWM]);
      if (int'(img[base+CWM+1]) > m) m = int'(img[base+CWM+1]);
      if (cap_by_addr[k] != m) mism++;
    end
    check("model_windows", mism, 0);

    for (int v = 0; v < 14; v++) begin
      if (vecs[v].kind == kind)
        check($sformatf("vec%0d_k%0d_a%0d", v, kind, vecs[v].addr),
              cap_by_addr[vecs[v].addr], vecs[v].exp);
    end

    repeat (3) @(negedge clk);
    check("done_held", int'(out_done), 1);
    in_done = 1'b0;
    @(negedge clk);
    check("done_clear", int'(out_done), 0);
    check("busy_after", int'(busy), 0);
  endtask

  initial begin
    int start;
    vecs[0]  = '{0, 0, 27};
    vecs[1]  = '{0, 168, 163};
    vecs[2]  = '{0, 1, 29};
    vecs[3]  = '{0, 13, 79};
    vecs[4]  = '{0, 12, 51};
    vecs[5]  = '{0, 63, 231};
    vecs[6]  = '{1, 13, 200};
    vecs[7]  = '{1, 0, 0};
    vecs[8]  = '{1, 14, 0};
    vecs[9]  = '{1, 26, 0};
    vecs[10] = '{2, 0, 255};
    vecs[11] = '{2, 168, 119};
    vecs[12] = '{2, 63, 255};
    vecs[13] = '{1, 1, 0};

    rst      = 1'b1;
    in_store = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    in_done  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({out_data, out_addr, out_store, out_done, busy, err}), 0);
    rst = 1'b0;

    fill(0);
    write_frame(1'b0);
    pool_frame(0, 1'b0);
    check("err_clean", int'(err), 0);

    fill(1);
    write_frame(1'b0);
    pool_frame(1, 1'b0);

    fill(0);
    write_frame(1'b1);
    pool_frame(0, 1'b1);
    check("err_dropped", int'(err), 1);

    // Reset in the middle of a frame, at the window 50 strobe.
    write_frame(1'b0);
    @(negedge clk);
    in_done = 1'b1;
    start   = cyc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cyc - start >= 306) break;
    end
    check("win50_strobe", int'(out_store), 1);
    check("win50_addr", int'(out_addr), 50);
    rst     = 1'b1;
    in_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_outputs", int'({out_data, out_addr, out_store, out_done, busy, err}), 0);
    @(negedge clk);
    check("rst_collect", int'({out_store, busy, out_done}), 0);

    write_frame(1'b0);
    pool_frame(0, 1'b0);

    fill(2);
    write_frame(1'b0);
    pool_frame(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_reader.md
# pool_reader

Consumer at the far end of the convolution engine's output protocol. It captures the `result`/`address`/`store` write stream into a local feature-map RAM. When the engine raises `done`, it reads the stored map back and performs 2x2 stride-2 max pooling. Pooled values are emitted on an identical `data`/`address`/`store`/`done` protocol, so the next layer sees the same interface the convolution engine drives.

## Interface
Parameters:
- `H`, 28, input image height (same value given to the convolution engine); conv map height CH = H-2
- `W`, 28, input image width; conv map width CW = W-2; pooled map PH = CH/2, PW = CW/2 (floor; odd last row/column dropped)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_store`  in  1  write strobe from convolution engine
- `in_addr`  in  10  conv-map address, row-major, r*CW+c
- `in_data`  in  8  conv result, unsigned
- `in_done`  in  1  conv-frame complete, level
- `out_data`  out  8  pooled max, unsigned
- `out_addr`  out  10  pooled address, row-major, pr*PW+pc
- `out_store`  out  1  one-cycle strobe per pooled value
- `out_done`  out  1  pooled frame complete, level
- `busy`  out  1  pooling in progress
- `err`  out  1  sticky: a write was dropped

## Operation
- Reset:
  - All outputs are 0.
  - State returns to COLLECT and the window counters return to 0.
  - RAM contents are not cleared.
- COLLECT:
  - `in_store`=1 with `in_addr` < CH*CW writes mem[in_addr] = in_data.
  - A write with `in_addr` >= CH*CW is dropped and sets `err`.
  - `in_done`=1 moves the FSM to RD with window index (pr,pc) = (0,0).
  - If `in_store` and `in_done` are high in the same cycle, the write completes first.
- RD, 4 cycles, sub-index s = 0..3:
  - Issues RAM reads in order (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
  - Read data returns one cycle later and is folded into the max register.
  - The max register is loaded, not compared, for s=0.
- FOLD, 1 cycle: folds the 4th read datum.
- EMIT, 1 cycle:
  - `out_store`=1, `out_data`=max, `out_addr`=pr*PW+pc.
  - If the window was the last one, go to HOLD.
  - Otherwise advance pc, wrapping to 0 and incrementing pr at PW-1, then go to RD.
- HOLD:
  - `out_done`=1 and stays high while `in_done`=1.
  - The first cycle `in_done`=0 clears `out_done` and returns the FSM to COLLECT, ready for the next frame.
- `in_store` while in RD, FOLD, EMIT or HOLD is dropped and sets `err`. RAM is not modified.
- `err` clears only on `rst`.
- Comparison is unsigned 8-bit; no saturation or width growth.
- `busy` = 1 in RD, FOLD and EMIT.

## Timing
- Let cycle 0 be the COLLECT cycle in which `in_done` is sampled high.
- The first read is issued in cycle 1; the first `out_store` is high in cycle 6.
- Window period is 6 cycles; window k strobes in cycle 6(k+1).
- The last strobe (k = PH*PW-1 = 168 at defaults) is in cycle 1014. `out_done` rises in cycle 1015.
- All outputs are registered; `out_data`/`out_addr` are valid only while `out_store`=1 and hold their values otherwise.
- RAM is synchronous with 1-cycle read latency. Reads and writes never occur in the same cycle, so a single-port RAM is sufficient.
- `rst` during any state takes effect on the next edge; the partially pooled frame is abandoned.

## Structure
- Shared package `conv_pkg`:
  - `ADDR_W`=10, `DATA_W`=8
  - FSM state enum: COLLECT, RD, FOLD, EMIT, HOLD
  - Frame-geometry helper constants CH, CW, PH, PW
- Sub-module `fmap_ram`: single-port synchronous RAM, depth CH*CW (676), 8-bit wide, with write enable. Everything else (FSM, window counters, max register, address generation) lives in `pool_reader`.

## Test plan
- Ramp: write mem[a] = a mod 256 for a = 0..675, then raise `in_done`.
  - Expect 169 strobes.
  - `out_addr` 0 -> 27 (max of 0, 1, 26, 27).
  - `out_addr` 168 -> 163 (max of 136, 137, 162, 163).
- Single hot: all zeros except mem[53]=200 (r2,c1), then done.
  - Expect `out_addr` 13 -> 200 (pr1,pc0); every other output 0.
- Cycle count:
  - First `out_store` 6 cycles after `in_done` is sampled; strobes exactly 6 apart.
  - `out_done` at cycle 1015, held until `in_done` falls.
  - `busy` is 0 in COLLECT and HOLD.
- Dropped writes: `in_store` pulse during RD with addr 0, data 255, and a separate COLLECT write to addr 700.
  - `err`=1.
  - Pooled output is identical to the ramp case.
- Reset: assert `rst` at window 50.
  - Next cycle: all outputs 0, state COLLECT.
  - A fresh ramp frame then reproduces the ramp results exactly.
- Back-to-back frames: drop `in_done`, refill with the inverted ramp (255 - a mod 256), re-raise `in_done`.
  - Second frame `out_addr` 0 -> 255 (max of 255, 254, 229, 228).
  - `out_done` deasserts between frames.
